// File: rtl/mem_loader_pkg.sv
// rtl/mem_loader_pkg.sv - state encodings, default depths and header layout for mem_loader
package mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_D  = 3'd1,
    ST_HDR_I  = 3'd2,
    ST_LOAD_D = 3'd3,
    ST_LOAD_I = 3'd4,
    ST_CHK    = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } state_t;

  localparam int DEF_I_DEPTH = 1024;
  localparam int DEF_D_DEPTH = 1024;
  localparam int IDX_W       = 11;

  // Header word positions within the stream.
  localparam int HDR_ND_POS  = 0;
  localparam int HDR_NI_POS  = 1;

  function automatic logic [IDX_W+1:0] word_byte_addr(input logic [IDX_W-1:0] idx);
    return {idx, 2'b00};
  endfunction

endpackage

// File: rtl/loader_checksum.sv
// rtl/loader_checksum.sv - modular-sum accumulator with clear and add-enable
module loader_checksum #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             add_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (add_en) begin
      sum_d = sum_q + din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - boot loader streaming header, data and instruction images into BRAM write ports
// Optional trailing checksum word is enabled by defining LOADER_CHECKSUM_EN.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int I_DEPTH    = DEF_I_DEPTH,
  parameter int D_DEPTH    = DEF_D_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic [3:0]            i_w_byte_enb,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic [3:0]            d_w_byte_enb,
  output logic                  cpu_hold,
  output logic                  d_init_done,
  output logic                  done,
  output logic                  error
);

  localparam logic [DATA_WIDTH-1:0] D_LIM = DATA_WIDTH'(D_DEPTH);
  localparam logic [DATA_WIDTH-1:0] I_LIM = DATA_WIDTH'(I_DEPTH);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t FINAL_ST = ST_CHK;
`else
  localparam state_t FINAL_ST = ST_DONE;
`endif

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      nd_q, nd_d;
  logic [IDX_W-1:0]      ni_q, ni_d;
  logic                  done_q, done_d;
  logic                  wr_d, wr_i;
  logic                  d_w_enb_q, d_w_enb_d, i_w_enb_q, i_w_enb_d;
  logic [ADDR_WIDTH-1:0] d_w_addr_q, d_w_addr_d, i_w_addr_q, i_w_addr_d;
  logic [DATA_WIDTH-1:0] d_w_dat_q, d_w_dat_d, i_w_dat_q, i_w_dat_d;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  last_word;

  assign cur_addr  = ADDR_WIDTH'(word_byte_addr(idx_q));

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] chk_sum;
  logic                  chk_clr;

  assign chk_clr = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);

  loader_checksum #(.WIDTH(DATA_WIDTH)) u_checksum (
    .clk    (clk),
    .rst    (rst),
    .clr    (chk_clr),
    .add_en (wr_d | wr_i),
    .din    (s_data),
    .sum    (chk_sum)
  );
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    nd_d      = nd_q;
    ni_d      = ni_q;
    s_ready   = 1'b0;
    wr_d      = 1'b0;
    wr_i      = 1'b0;
    last_word = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_HDR_D;
          idx_d   = '0;
        end
      end
      ST_HDR_D: begin
        s_ready = 1'b1;
        if (s_valid) begin
          nd_d    = s_data[IDX_W-1:0];
          state_d = (s_data > D_LIM) ? ST_ERR : ST_HDR_I;
        end
      end
      ST_HDR_I: begin
        s_ready = 1'b1;
        if (s_valid) begin
          ni_d = s_data[IDX_W-1:0];
          if (s_data > I_LIM)        state_d = ST_ERR;
          else if (nd_q != '0)       state_d = ST_LOAD_D;
          else if (s_data == '0)     state_d = FINAL_ST;
          else                       state_d = ST_LOAD_I;
        end
      end
      ST_LOAD_D: begin
        s_ready = 1'b1;
        if (s_valid) begin
          wr_d      = 1'b1;
          last_word = (idx_q == nd_q - IDX_W'(1));
          idx_d     = last_word ? '0 : idx_q + IDX_W'(1);
          if (last_word) state_d = (ni_q == '0) ? FINAL_ST : ST_LOAD_I;
        end
      end
      ST_LOAD_I: begin
        s_ready = 1'b1;
        if (s_valid) begin
          wr_i      = 1'b1;
          last_word = (idx_q == ni_q - IDX_W'(1));
          idx_d     = last_word ? '0 : idx_q + IDX_W'(1);
          if (last_word) state_d = FINAL_ST;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHK: begin
        s_ready = 1'b1;
        if (s_valid) state_d = (s_data == chk_sum) ? ST_DONE : ST_ERR;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    d_w_enb_d  = wr_d;
    d_w_addr_d = wr_d ? cur_addr : d_w_addr_q;
    d_w_dat_d  = wr_d ? s_data : d_w_dat_q;
    i_w_enb_d  = wr_i;
    i_w_addr_d = wr_i ? cur_addr : i_w_addr_q;
    i_w_dat_d  = wr_i ? s_data : i_w_dat_q;

    // Lags DONE entry by a cycle so the final strobe lands before the datapath owns the port.
    done_d = (state_q == ST_DONE) && (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      nd_q       <= '0;
      ni_q       <= '0;
      done_q     <= 1'b0;
      d_w_enb_q  <= 1'b0;
      d_w_addr_q <= '0;
      d_w_dat_q  <= '0;
      i_w_enb_q  <= 1'b0;
      i_w_addr_q <= '0;
      i_w_dat_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      nd_q       <= nd_d;
      ni_q       <= ni_d;
      done_q     <= done_d;
      d_w_enb_q  <= d_w_enb_d;
      d_w_addr_q <= d_w_addr_d;
      d_w_dat_q  <= d_w_dat_d;
      i_w_enb_q  <= i_w_enb_d;
      i_w_addr_q <= i_w_addr_d;
      i_w_dat_q  <= i_w_dat_d;
    end
  end

  assign d_w_enb      = d_w_enb_q;
  assign d_w_addr     = d_w_addr_q;
  assign d_w_dat      = d_w_dat_q;
  assign d_w_byte_enb = {4{d_w_enb_q}};
  assign i_w_enb      = i_w_enb_q;
  assign i_w_addr     = i_w_addr_q;
  assign i_w_dat      = i_w_dat_q;
  assign i_w_byte_enb = {4{i_w_enb_q}};
  assign done         = done_q;
  assign d_init_done  = done_q;
  assign cpu_hold     = ~done_q;
  assign error        = (state_q == ST_ERR);

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - randomized self-checking bench for mem_loader against a write-list model
module tb_mem_loader;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready, i_w_enb, d_w_enb, cpu_hold, d_init_done, done, error;
  logic [11:0] i_w_addr, d_w_addr;
  logic [31:0] i_w_dat, d_w_dat;
  logic [3:0]  i_w_byte_enb, d_w_byte_enb;

  always #5 clk = ~clk;

  mem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .I_DEPTH(1024), .D_DEPTH(1024)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb), .i_w_byte_enb(i_w_byte_enb),
    .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb), .d_w_byte_enb(d_w_byte_enb),
    .cpu_hold(cpu_hold), .d_init_done(d_init_done), .done(done), .error(error)
  );

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, last_strobe_cyc = -1, done_rise_cyc = -1, hold_bad = 0;
  bit done_prev = 0;
  logic [47:0] dlog[$], ilog[$];
  logic [31:0] img_d[$], img_i[$];
  localparam logic [81:0] RESET_VEC = {1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 12'h0, 12'h0, 32'h0, 4'b1000};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (d_w_enb) begin dlog.push_back({d_w_addr, d_w_dat, d_w_byte_enb}); last_strobe_cyc = cyc; if (!cpu_hold) hold_bad++; end
    if (i_w_enb) begin ilog.push_back({i_w_addr, i_w_dat, i_w_byte_enb}); last_strobe_cyc = cyc; if (!cpu_hold) hold_bad++; end
    if (done && !done_prev) done_rise_cyc = cyc;
    done_prev = done;
  end

  function automatic logic [47:0] exp_entry(input int k, input logic [31:0] w);
    return {12'(4 * k), w, 4'hF};
  endfunction

  function automatic logic [81:0] out_vec();
    return {s_ready, d_w_enb, i_w_enb, d_w_byte_enb, i_w_byte_enb, d_w_addr, i_w_addr,
            d_w_dat | i_w_dat, cpu_hold, d_init_done, done, error};
  endfunction

  task automatic send_word(input logic [31:0] w, output bit ok);
    int t = 0;
    ok = 0; s_valid = 1'b1; s_data = w;
    while (!ok && t < 16) begin
      ok = (s_ready === 1'b1);
      @(negedge clk);
      t++;
    end
    s_valid = 1'b0;
  endtask

  task automatic load_image(input bit gaps, input bit corrupt, output int tmo, output int drops);
    logic [31:0] words[$];
    logic [31:0] sum = '0;
    bit ok;
    tmo = 0; drops = 0;
    words.push_back(32'(img_d.size()));
    words.push_back(32'(img_i.size()));
    foreach (img_d[k]) begin words.push_back(img_d[k]); sum += img_d[k]; end
    foreach (img_i[k]) begin words.push_back(img_i[k]); sum += img_i[k]; end
`ifdef LOADER_CHECKSUM_EN
    words.push_back(corrupt ? sum + 32'd1 : sum);
`else
    if (corrupt) sum = '0;
`endif
    @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    foreach (words[k]) begin
      send_word(words[k], ok);
      if (!ok) tmo++;
      if (gaps && k < words.size() - 1) begin
        @(negedge clk);
        if (s_ready !== 1'b1) drops++;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic fill(input int nd, input int ni);
    img_d.delete(); img_i.delete();
    for (int k = 0; k < nd; k++) img_d.push_back($urandom);
    for (int k = 0; k < ni; k++) img_i.push_back($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (out_vec() !== RESET_VEC) begin n_bad++; $display("FAIL reset_outputs: got %h expected %h", out_vec(), RESET_VEC); end
    rst = 1'b1; s_valid = 1'b1; s_data = 32'd5;
    repeat (4) @(negedge clk);
    s_valid = 1'b0;
    n_cmp++; if (out_vec() !== RESET_VEC) begin n_bad++; $display("FAIL idle_ignores_stream: got %h expected %h", out_vec(), RESET_VEC); end
  endtask

  task automatic test_back_to_back(input bit gaps, input string tag);
    int bd = dlog.size(), bi = ilog.size(), tmo, drops;
    load_image(gaps, 1'b0, tmo, drops);
    n_cmp++; if (tmo != 0 || drops != 0) begin n_bad++; $display("FAIL %s_ready: timeouts %0d drops %0d expected 0 0", tag, tmo, drops); end
    n_cmp++; if (dlog.size() - bd != img_d.size()) begin n_bad++; $display("FAIL %s_d_count: got %0d expected %0d", tag, dlog.size() - bd, img_d.size()); end
    else foreach (img_d[k]) begin
      n_cmp++; if (dlog[bd+k] !== exp_entry(k, img_d[k])) begin n_bad++; $display("FAIL %s_d_write%0d: got %h expected %h", tag, k, dlog[bd+k], exp_entry(k, img_d[k])); end
    end
    n_cmp++; if (ilog.size() - bi != img_i.size()) begin n_bad++; $display("FAIL %s_i_count: got %0d expected %0d", tag, ilog.size() - bi, img_i.size()); end
    else foreach (img_i[k]) begin
      n_cmp++; if (ilog[bi+k] !== exp_entry(k, img_i[k])) begin n_bad++; $display("FAIL %s_i_write%0d: got %h expected %h", tag, k, ilog[bi+k], exp_entry(k, img_i[k])); end
    end
    n_cmp++; if ({done, cpu_hold, d_init_done, error, s_ready} !== 5'b10100) begin n_bad++; $display("FAIL %s_status: got %b expected 10100", tag, {done, cpu_hold, d_init_done, error, s_ready}); end
    if (img_d.size() + img_i.size() > 0) begin
      n_cmp++; if (done_rise_cyc != last_strobe_cyc + 1) begin n_bad++; $display("FAIL %s_done_timing: got %0d expected %0d", tag, done_rise_cyc, last_strobe_cyc + 1); end
    end
    n_cmp++; if (hold_bad != 0) begin n_bad++; $display("FAIL %s_hold_during_load: got %0d expected 0", tag, hold_bad); end
  endtask

  task automatic test_overflow();
    int bd, bi;
    bit ok;
    @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    bd = dlog.size(); bi = ilog.size();
    send_word(32'd1025, ok);
    n_cmp++; if ({ok, error, s_ready, cpu_hold, done} !== 5'b11010) begin n_bad++; $display("FAIL nd_overflow: got %b expected 11010", {ok, error, s_ready, cpu_hold, done}); end
    s_valid = 1'b1; s_data = $urandom;
    repeat (4) @(negedge clk);
    s_valid = 1'b0;
    n_cmp++; if (dlog.size() + ilog.size() != bd + bi || error !== 1'b1) begin n_bad++; $display("FAIL err_sticky: strobes %0d error %b expected 0 1", dlog.size() + ilog.size() - bd - bi, error); end
    @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    send_word(32'd1, ok);
    send_word(32'd1025, ok);
    n_cmp++; if ({ok, error, cpu_hold, dlog.size() == bd} !== 4'b1111) begin n_bad++; $display("FAIL ni_overflow: got %b expected 1111", {ok, error, cpu_hold, dlog.size() == bd}); end
  endtask

  task automatic test_reset_mid();
    int bd = dlog.size(), bi = ilog.size();
    bit ok;
    fill(4, 2);
    @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    send_word(32'd4, ok); send_word(32'd2, ok);
    send_word(img_d[0], ok); send_word(img_d[1], ok);
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (out_vec() !== RESET_VEC) begin n_bad++; $display("FAIL midreset_outputs: got %h expected %h", out_vec(), RESET_VEC); end
    repeat (2) @(negedge clk);
    rst = 1'b1; s_valid = 1'b1; s_data = $urandom;
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    n_cmp++; if (dlog.size() - bd != 2 || ilog.size() != bi) begin n_bad++; $display("FAIL midreset_strobes: got %0d/%0d expected 2/0", dlog.size() - bd, ilog.size() - bi); end
    else begin
      n_cmp++; if (dlog[bd+1] !== exp_entry(1, img_d[1])) begin n_bad++; $display("FAIL midreset_partial: got %h expected %h", dlog[bd+1], exp_entry(1, img_d[1])); end
    end
    n_cmp++; if (out_vec() !== RESET_VEC) begin n_bad++; $display("FAIL midreset_idle: got %h expected %h", out_vec(), RESET_VEC); end
  endtask

  task automatic test_restart();
    bit ok;
    @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    n_cmp++; if ({done, cpu_hold, d_init_done, s_ready} !== 4'b0101) begin n_bad++; $display("FAIL restart_clears: got %b expected 0101", {done, cpu_hold, d_init_done, s_ready}); end
    send_word(32'd0, ok); send_word(32'd0, ok);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'd0, ok);
`endif
    repeat (3) @(negedge clk);
    n_cmp++; if ({ok, done, cpu_hold, error} !== 4'b1100) begin n_bad++; $display("FAIL empty_image: got %b expected 1100", {ok, done, cpu_hold, error}); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int tmo, drops;
    img_d.delete(); img_i.delete();
    img_d.push_back(32'h10); img_i.push_back(32'h20);
    load_image(1'b0, 1'b0, tmo, drops);
    n_cmp++; if ({done, error, cpu_hold} !== 3'b100) begin n_bad++; $display("FAIL chk_match: got %b expected 100", {done, error, cpu_hold}); end
    load_image(1'b0, 1'b1, tmo, drops);
    n_cmp++; if ({done, error, cpu_hold} !== 3'b011) begin n_bad++; $display("FAIL chk_mismatch: got %b expected 011", {done, error, cpu_hold}); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    img_d.delete(); img_i.delete();
    img_d.push_back(32'h1); img_d.push_back(32'h2); img_d.push_back(32'h3);
    for (int k = 0; k < 7; k++) img_i.push_back($urandom);
    test_back_to_back(1'b0, "b2b");
    test_back_to_back(1'b1, "stall");
    test_overflow();
    fill(2, 1);
    test_back_to_back(1'b0, "after_err");
    fill(0, 2);
    test_back_to_back(1'b0, "nd_zero");
    test_reset_mid();
    fill(4, 2);
    test_back_to_back(1'b0, "after_reset");
    test_restart();
    fill(1024, 1);
    test_back_to_back(1'b0, "nd_max");
    for (int r = 0; r < 4; r++) begin
      fill($urandom_range(0, 10), $urandom_range(0, 10));
      test_back_to_back(1'($urandom_range(0, 1)), "random");
    end
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
